// File: rtl/mux8_serializer_pkg.sv
// ---------------------------------------------------------------------------
// mux8_serializer_pkg
//   Shared types and constants for the 8-bit parallel-to-serial front end
//   that drives the 8:1 multiplexer.
//   - state_t     : serializer FSM encoding (IDLE / SHIFT)
//   - WORD_W/SEL_W: word width and select-counter width
//   - sel_start / sel_end : first and last select value for a bit order
// ---------------------------------------------------------------------------
package mux8_serializer_pkg;

   localparam int WORD_W = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // First select value of a word: bit 0 for LSB-first, bit 7 otherwise.
   function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
      return lsb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
   endfunction

   // Last select value of a word.
   function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
      return lsb_first ? SEL_W'(WORD_W - 1) : SEL_W'(0);
   endfunction

endpackage

// File: rtl/mux8_serializer_mux8x1.sv
// ---------------------------------------------------------------------------
// mux8x1
//   Existing 8:1 data-flow multiplexer, used as-is.
//   i : 8 data inputs
//   s : 3-bit select
//   y : selected bit, y = i[s]
// ---------------------------------------------------------------------------
module mux8x1 (
   input  logic [7:0] i,
   input  logic [2:0] s,
   output logic       y
);

   assign y = i[s];

endmodule

// File: rtl/mux8_serializer.sv
// ---------------------------------------------------------------------------
// mux8_serializer
//   Accepts one 8-bit word per valid/ready handshake, holds it, and walks a
//   3-bit select counter across the eight bit positions of the 8:1 mux,
//   producing one bit per cycle on a valid/ready serial stream with
//   first/last markers. A word arriving on the last-bit edge is loaded
//   directly, so back-to-back words stream with no gap.
//
//   Parameters
//     LSB_FIRST  : 1 -> bit order 0..7, 0 -> bit order 7..0
//     IDLE_LEVEL : level driven on o_ser_out while no word is shifting
//
//   Ports
//     i_clk        rising-edge clock
//     i_rst_n      asynchronous active-low reset
//     i_in_data    parallel word
//     i_in_valid   i_in_data valid
//     o_in_ready   word accepted this cycle (combinational from i_ser_ready)
//     o_sel        current select counter value
//     o_ser_out    serial bit = held_word[sel], IDLE_LEVEL when idle
//     o_ser_valid  o_ser_out valid
//     o_ser_first  current bit is the first of the word
//     o_ser_last   current bit is the last of the word
//     i_ser_ready  downstream consumes o_ser_out this cycle
// ---------------------------------------------------------------------------
module mux8_serializer
   import mux8_serializer_pkg::*;
#(
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [WORD_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [SEL_W-1:0]  o_sel,
   output logic              o_ser_out,
   output logic              o_ser_valid,
   output logic              o_ser_first,
   output logic              o_ser_last,
   input  logic              i_ser_ready
);

   localparam logic [SEL_W-1:0] SEL_START = sel_start(LSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_END   = sel_end(LSB_FIRST);

   state_t              r_state;
   logic [WORD_W-1:0]   r_held;
   logic [SEL_W-1:0]    r_sel;

   state_t              w_state_nxt;
   logic [WORD_W-1:0]   w_held_nxt;
   logic [SEL_W-1:0]    w_sel_nxt;
   logic                w_in_ready;
   logic                w_ser_valid;
   logic                w_ser_first;
   logic                w_ser_last;
   logic                w_raw_bit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_held  <= '0;
         r_sel   <= SEL_START;
      end else begin
         r_state <= w_state_nxt;
         r_held  <= w_held_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_held_nxt  = r_held;
      w_sel_nxt   = r_sel;
      w_in_ready  = 1'b0;
      w_ser_valid = 1'b0;
      w_ser_first = 1'b0;
      w_ser_last  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (i_in_valid) begin
               w_held_nxt  = i_in_data;
               w_sel_nxt   = SEL_START;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_ser_valid = 1'b1;
            w_ser_first = (r_sel == SEL_START);
            w_ser_last  = (r_sel == SEL_END);
            if (i_ser_ready) begin
               if (w_ser_last) begin
                  // Word end: a waiting word reloads in place (no gap cycle).
                  w_in_ready = 1'b1;
                  if (i_in_valid) begin
                     w_held_nxt = i_in_data;
                     w_sel_nxt  = SEL_START;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_sel_nxt = LSB_FIRST ? r_sel + SEL_W'(1) : r_sel - SEL_W'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   mux8x1 u_mux (
      .i (r_held),
      .s (r_sel),
      .y (w_raw_bit)
   );

   // IDLE state would otherwise advertise ready during reset.
   assign o_in_ready  = w_in_ready & i_rst_n;
   assign o_sel       = r_sel;
   assign o_ser_out   = (r_state == ST_SHIFT) ? w_raw_bit : IDLE_LEVEL;
   assign o_ser_valid = w_ser_valid;
   assign o_ser_first = w_ser_first;
   assign o_ser_last  = w_ser_last;

endmodule

// File: tb/tb_mux8_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux8_serializer
//   Directed bench for mux8_serializer. Two instances share the stimulus:
//   u_lsb (LSB_FIRST=1, IDLE_LEVEL=0) and u_msb (LSB_FIRST=0, IDLE_LEVEL=1).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
//   Observation vector: {in_ready, ser_valid, ser_first, ser_last, ser_out, sel}.
// ---------------------------------------------------------------------------
module tb_mux8_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       ser_ready = 1'b1;

   logic       l_in_ready, l_ser_out, l_ser_valid, l_ser_first, l_ser_last;
   logic [2:0] l_sel;
   logic       m_in_ready, m_ser_out, m_ser_valid, m_ser_first, m_ser_last;
   logic [2:0] m_sel;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wire [7:0] l_obs = {l_in_ready, l_ser_valid, l_ser_first, l_ser_last, l_ser_out, l_sel};
   wire [7:0] m_obs = {m_in_ready, m_ser_valid, m_ser_first, m_ser_last, m_ser_out, m_sel};

   mux8_serializer #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
      .o_in_ready(l_in_ready), .o_sel(l_sel), .o_ser_out(l_ser_out),
      .o_ser_valid(l_ser_valid), .o_ser_first(l_ser_first), .o_ser_last(l_ser_last),
      .i_ser_ready(ser_ready)
   );

   mux8_serializer #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
      .o_in_ready(m_in_ready), .o_sel(m_sel), .o_ser_out(m_ser_out),
      .o_ser_valid(m_ser_valid), .o_ser_first(m_ser_first), .o_ser_last(m_ser_last),
      .i_ser_ready(ser_ready)
   );

   task automatic test_reset();
      logic [7:0] exp;
      rst_n = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
      @(negedge clk); #1;
      exp = 8'b0_0000_000;
      n_vec++;
      if (l_obs !== exp) begin n_err++; $display("FAIL reset_lsb: got %b want %b", l_obs, exp); end
      exp = 8'b0_0001_111;
      n_vec++;
      if (m_obs !== exp) begin n_err++; $display("FAIL reset_msb: got %b want %b", m_obs, exp); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         exp = 8'b1_0000_000;
         n_vec++;
         if (l_obs !== exp) begin n_err++; $display("FAIL idle_lsb: got %b want %b", l_obs, exp); end
         exp = 8'b1_0001_111;
         n_vec++;
         if (m_obs !== exp) begin n_err++; $display("FAIL idle_msb: got %b want %b", m_obs, exp); end
      end
   endtask

   task automatic test_lsb_single();
      logic [7:0] w = 8'hA5;
      logic [7:0] exp;
      @(negedge clk); in_data = w; in_valid = 1'b1; #1;
      n_vec++;
      if (l_in_ready !== 1'b1) begin n_err++; $display("FAIL lsb_accept_ready: got %b want 1", l_in_ready); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); in_valid = 1'b0; in_data = 8'h3C; #1;
         exp = {i == 7, 1'b1, i == 0, i == 7, w[i], 3'(i)};
         n_vec++;
         if (l_obs !== exp) begin n_err++; $display("FAIL lsb_single bit%0d: got %b want %b", i, l_obs, exp); end
      end
      @(negedge clk); #1;
      n_vec++;
      if (l_obs[7:3] !== 5'b10000) begin n_err++; $display("FAIL lsb_single_end: got %b want 10000", l_obs[7:3]); end
      n_vec++;
      if (m_obs[7:3] !== 5'b10001) begin n_err++; $display("FAIL msb_idle_level: got %b want 10001", m_obs[7:3]); end
   endtask

   task automatic test_msb_first();
      logic [7:0] words [2] = '{8'hA5, 8'h01};
      logic [7:0] w;
      logic [7:0] exp;
      for (int k = 0; k < 2; k++) begin
         w = words[k];
         @(negedge clk); in_data = w; in_valid = 1'b1; #1;
         n_vec++;
         if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL msb_accept_ready: got %b want 1", m_in_ready); end
         for (int i = 0; i < 8; i++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            exp = {i == 7, 1'b1, i == 0, i == 7, w[7-i], 3'(7 - i)};
            n_vec++;
            if (m_obs !== exp) begin n_err++; $display("FAIL msb word%0d bit%0d: got %b want %b", k, i, m_obs, exp); end
         end
         @(negedge clk); #1;
         n_vec++;
         if (m_obs[7:3] !== 5'b10001) begin n_err++; $display("FAIL msb_end word%0d: got %b want 10001", k, m_obs[7:3]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      @(negedge clk); in_data = 8'hFF; in_valid = 1'b1; #1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         in_data  = 8'h00;
         in_valid = (c <= 8);
         #1;
         exp = {((c - 1) % 8) == 7, 1'b1, ((c - 1) % 8) == 0, ((c - 1) % 8) == 7,
                c <= 8, 3'((c - 1) % 8)};
         n_vec++;
         if (l_obs !== exp) begin n_err++; $display("FAIL b2b cycle%0d: got %b want %b", c, l_obs, exp); end
      end
      @(negedge clk); #1;
      n_vec++;
      if (l_obs[7:3] !== 5'b10000) begin n_err++; $display("FAIL b2b_end: got %b want 10000", l_obs[7:3]); end
   endtask

   task automatic test_stall();
      logic [7:0] w = 8'h0F;
      logic [7:0] exp;
      logic [2:0] s;
      @(negedge clk); in_data = w; in_valid = 1'b1; #1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         ser_ready = !(c >= 4 && c <= 6);
         #1;
         s = (c <= 4) ? 3'(c - 1) : (c <= 7) ? 3'd3 : 3'(c - 4);
         exp = {c == 11, 1'b1, c == 1, c == 11, w[s], s};
         n_vec++;
         if (l_obs !== exp) begin n_err++; $display("FAIL stall cycle%0d: got %b want %b", c, l_obs, exp); end
      end
      @(negedge clk); ser_ready = 1'b1; #1;
      n_vec++;
      if (l_obs[7:3] !== 5'b10000) begin n_err++; $display("FAIL stall_end: got %b want 10000", l_obs[7:3]); end
   endtask

   task automatic test_reset_midword();
      logic [7:0] exp;
      @(negedge clk); in_data = 8'hA5; in_valid = 1'b1; #1;
      repeat (5) begin
         @(negedge clk); in_valid = 1'b0;
      end
      #1;
      exp = 8'b0_1000_100;
      n_vec++;
      if (l_obs !== exp) begin n_err++; $display("FAIL midword_pre: got %b want %b", l_obs, exp); end
      rst_n = 1'b0; #1;
      exp = 8'b0_0000_000;
      n_vec++;
      if (l_obs !== exp) begin n_err++; $display("FAIL midword_reset_lsb: got %b want %b", l_obs, exp); end
      exp = 8'b0_0001_111;
      n_vec++;
      if (m_obs !== exp) begin n_err++; $display("FAIL midword_reset_msb: got %b want %b", m_obs, exp); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         exp = 8'b1_0000_000;
         n_vec++;
         if (l_obs !== exp) begin n_err++; $display("FAIL midword_idle cycle%0d: got %b want %b", c, l_obs, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_lsb_single();
      test_msb_first();
      test_back_to_back();
      test_stall();
      test_reset_midword();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux8_serializer.md
Name: mux8_serializer

Overview:
- Upstream control and holding stage for the existing 8:1 data-flow multiplexer.
- Accepts one 8-bit word per valid/ready handshake and holds it in a register.
- Steps a 3-bit select counter through the eight bit positions and drives the multiplexer's data and select inputs.
- Presents one bit per cycle on a serial valid/ready stream, with first/last markers.

Parameters:
- LSB_FIRST, 1, 1: bit order 0→7; 0: bit order 7→0.
- IDLE_LEVEL, 0, value forced onto ser_out while no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- sel  output  3  current select value (mirror of the internal select counter).
- ser_out  output  1  serial bit = held_word[sel].
- ser_valid  output  1  ser_out valid.
- ser_first  output  1  current bit is the first of the word.
- ser_last  output  1  current bit is the last of the word.
- ser_ready  input  1  downstream consumes ser_out this cycle.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state:
  - state=IDLE, held_word=0.
  - sel=0 if LSB_FIRST, else 7.
  - ser_valid=0, ser_first=0, ser_last=0, in_ready=0 while rst_n is low.
  - ser_out=IDLE_LEVEL.
- State machine: IDLE, SHIFT.
- IDLE:
  - in_ready=1.
  - On clk edge with in_valid=1:
    - held_word<=in_data.
    - sel<=start value (0, or 7 when LSB_FIRST=0).
    - state<=SHIFT.
- SHIFT:
  - ser_valid=1.
  - ser_first=1 when sel==start value.
  - ser_last=1 when sel==end value (7, or 0 when LSB_FIRST=0).
- Step: on an edge with ser_ready=1 and not last, sel advances by one (+1 for LSB_FIRST, else -1).
- Stall: while ser_ready=0, sel, held_word and all serial outputs hold.
- Word end: on an edge with ser_ready=1 and ser_last=1:
  - If in_valid=1: load the new word and restart sel, staying in SHIFT. This is back-to-back operation with no gap cycle.
  - Otherwise state<=IDLE.
- in_ready in SHIFT = ser_last & ser_ready.
  - Combinational from ser_ready. Upstream must not make in_valid depend on in_ready.
- Latency: word accepted at edge k → first bit valid in cycle k+1.
  - Unstalled, a word occupies exactly 8 cycles. Throughput is 1 word per 8 cycles.
- ser_out is produced by the 8:1 multiplexer from held_word and sel. Both are registered, so ser_out changes only after clock edges.
  - Gated to IDLE_LEVEL when state=IDLE.
- sel never wraps within a word. Wrap-around happens only through a reload at word end.
- in_data is sampled only on an accepting edge. Changes at other times are ignored.
- Reset mid-word: the word is discarded and the block returns to IDLE. No partial-word completion after reset release.
- in_valid=1 during SHIFT before the last bit: in_ready=0, so the word is not taken. The upstream source must hold the word.

Decomposition:
- Shared package (or header of defines) holds:
  - state encoding IDLE/SHIFT;
  - width constants WORD_W=8, SEL_W=3;
  - start/end select constants derived from LSB_FIRST.
- One sub-module: the existing 8:1 multiplexer (mux8x1), instantiated unchanged.
  - i=held_word, s=sel, y=raw serial bit.
  - The IDLE gate is applied outside it.

Test Plan:
- Reset/idle: rst_n=0 then 1, no input → ser_valid=0, ser_out=IDLE_LEVEL, in_ready=1, sel=0.
- Single word, LSB_FIRST=1, in_data=8'hA5, ser_ready=1:
  - ser_out sequence 1,0,1,0,0,1,0,1 over cycles k+1..k+8.
  - ser_first only in the first of these cycles, ser_last only in the eighth.
  - Back to IDLE at k+9.
- MSB first (LSB_FIRST=0), in_data=8'hA5 → sequence 1,0,1,0,0,1,0,1 with sel 7→0.
  - Repeat with 8'h01 → 0,0,0,0,0,0,0,1.
- Back-to-back: in_valid held high with 8'hFF then 8'h00:
  - 16 consecutive valid cycles (eight 1s, then eight 0s).
  - No idle gap; in_ready pulses only on each ser_last cycle.
- Stall: ser_ready=0 for 3 cycles while sel=3 (word 8'h0F, LSB first):
  - sel, ser_out=1 and ser_valid hold.
  - The sequence resumes with no lost or repeated bit; total 11 cycles.
- Reset mid-word: assert rst_n low while sel=4 → immediately ser_valid=0 and sel=0.
  - After release the block idles until a new in_valid; the old word is never emitted.
